keypad_event_encoder: RTL and testbench

Parametrised keypad event encoder. It sits between the 4x4 keypad scanner, which supplies a one-hot key vector, and the digit/command consumers. It debounces press and release, maps the key index to a code through a parameter table, and generates auto-repeat. Each event is delivered through a one-entry valid/ready output register, and an overrun flag reports events the consumer did not accept in time.

---
 rtl/keypad_event_encoder.sv | 182 ++++++++++++++++++
 tb/tb_keypad_event_encoder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_event_encoder.sv
// Keypad event encoder: debounces a one-hot key vector, maps the key to a code, adds auto-repeat,
// and hands each event to a one-entry valid/ready register that flags dropped events as overrun.
module keypad_event_encoder #(
  parameter int                       N_KEYS          = 16,
  parameter int                       CODE_W          = 4,
  parameter logic [N_KEYS*CODE_W-1:0] KEY_MAP         = 64'h789F_456E_123D_0CBA,
  parameter int                       DEBOUNCE_CYCLES = 16,
  parameter int                       REPEAT_DELAY    = 0,
  parameter int                       REPEAT_PERIOD   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] onehot,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [CODE_W-1:0] out_code,
  output logic              out_repeat,
  output logic              key_down,
  output logic [CODE_W-1:0] held_code,
  output logic              overrun
);

  localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_C = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEB,
    S_HELD,
    S_REL
  } state_t;

  state_t              state_q, state_d;
  logic [N_KEYS-1:0]   s_key_q;
  logic [N_KEYS-1:0]   cand_q, cand_d;
  logic [CW-1:0]       dcnt_q, dcnt_d;
  logic [CW-1:0]       rcnt_q, rcnt_d;
  logic                rphase_q, rphase_d;
  logic [CODE_W-1:0]   held_q, held_d;
  logic                vld_q, vld_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                rep_q, rep_d;
  logic                ovr_q, ovr_d;

  logic                single_hot;
  logic                match;
  logic [CODE_W-1:0]   cand_code;
  logic [CW-1:0]       rep_last;
  logic                ev;
  logic                ev_rep;

  // Zero or multi-hot (ghosting) both read as "no key".
  assign single_hot = (s_key_q != '0) && ((s_key_q & (s_key_q - N_KEYS'(1))) == '0);
  assign match      = (s_key_q == cand_q);
  assign rep_last   = rphase_q ? RP_LAST : RD_LAST;

  always_comb begin
    cand_code = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (cand_q[i]) cand_code = KEY_MAP[i*CODE_W +: CODE_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    dcnt_d   = dcnt_q;
    rcnt_d   = rcnt_q;
    rphase_d = rphase_q;
    held_d   = held_q;
    ev       = 1'b0;
    ev_rep   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (single_hot) begin
          cand_d  = s_key_q;
          dcnt_d  = CNT_ONE;
          state_d = S_DEB;
        end
      end
      S_DEB: begin
        if (!match) begin
          state_d = S_IDLE;
        end else if (dcnt_q == DEB_LAST) begin
          ev       = 1'b1;
          held_d   = cand_code;
          rcnt_d   = '0;
          rphase_d = 1'b0;
          state_d  = S_HELD;
        end else begin
          dcnt_d = dcnt_q + CNT_ONE;
        end
      end
      S_HELD: begin
        if (!match) begin
          dcnt_d  = CNT_ONE;
          state_d = S_REL;
        end else if (REPEAT_DELAY != 0) begin
          if (rcnt_q == rep_last) begin
            ev       = 1'b1;
            ev_rep   = 1'b1;
            rcnt_d   = '0;
            rphase_d = 1'b1;
          end else begin
            rcnt_d = rcnt_q + CNT_ONE;
          end
        end
      end
      S_REL: begin
        // A short dropout of the same key resumes HELD with repeat timing intact.
        if (match) begin
          state_d = S_HELD;
        end else if (dcnt_q == DEB_LAST) begin
          state_d = S_IDLE;
        end else begin
          dcnt_d = dcnt_q + CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vld_d  = vld_q;
    code_d = code_q;
    rep_d  = rep_q;
    ovr_d  = 1'b0;
    if (ev) begin
      if (!vld_q || out_ready) begin
        vld_d  = 1'b1;
        code_d = cand_code;
        rep_d  = ev_rep;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (vld_q && out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      s_key_q  <= '0;
      cand_q   <= '0;
      dcnt_q   <= '0;
      rcnt_q   <= '0;
      rphase_q <= 1'b0;
      held_q   <= '0;
      vld_q    <= 1'b0;
      code_q   <= '0;
      rep_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_key_q  <= onehot;
      cand_q   <= cand_d;
      dcnt_q   <= dcnt_d;
      rcnt_q   <= rcnt_d;
      rphase_q <= rphase_d;
      held_q   <= held_d;
      vld_q    <= vld_d;
      code_q   <= code_d;
      rep_q    <= rep_d;
      ovr_q    <= ovr_d;
    end
  end

  assign out_valid  = vld_q;
  assign out_code   = code_q;
  assign out_repeat = rep_q;
  assign key_down   = (state_q == S_HELD) || (state_q == S_REL);
  assign held_code  = held_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_keypad_event_encoder.sv
// Bench for keypad_event_encoder: directed scenarios plus random key traffic, every cycle
// compared against a behavioural model built from the default keypad code table.
module tb_keypad_event_encoder;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] onehot;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  out_code;
  logic        out_repeat;
  logic        key_down;
  logic [3:0]  held_code;
  logic        overrun;

  always #5 clk = ~clk;

  keypad_event_encoder #(
    .N_KEYS(16), .CODE_W(4), .KEY_MAP(64'h789F_456E_123D_0CBA),
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .onehot(onehot), .out_ready(out_ready),
    .out_valid(out_valid), .out_code(out_code), .out_repeat(out_repeat),
    .key_down(key_down), .held_code(held_code), .overrun(overrun)
  );

  // Keypad legend: digits and command codes per key position.
  logic [3:0] code_tbl [16] = '{4'hA, 4'hB, 4'hC, 4'h0, 4'hD, 4'h3, 4'h2, 4'h1,
                                4'hE, 4'h6, 4'h5, 4'h4, 4'hF, 4'h9, 4'h8, 4'h7};

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: 0 quiet, 1 settling, 2 down, 3 lifting.
  int         m_phase, m_key, m_sidx, m_settle, m_rep_cnt;
  bit         m_first_done;
  logic       m_vld, m_rep, m_ovr;
  logic [3:0] m_code, m_held;

  function automatic int key_index(input logic [15:0] v);
    int idx;
    idx = -1;
    if ($countones(v) == 1) begin
      for (int i = 0; i < 16; i++) if (v[i]) idx = i;
    end
    return idx;
  endfunction

  task automatic model_step(input logic [15:0] oh, input logic rdy, input logic r);
    bit fire, fire_rep;
    int need;
    fire = 0;
    fire_rep = 0;
    if (r) begin
      m_phase = 0; m_key = -1; m_sidx = -1; m_settle = 0; m_rep_cnt = 0; m_first_done = 0;
      m_vld = 0; m_rep = 0; m_ovr = 0; m_code = 0; m_held = 0;
      return;
    end
    if (m_phase == 0) begin
      if (m_sidx >= 0) begin m_key = m_sidx; m_settle = 1; m_phase = 1; end
    end else if (m_phase == 1) begin
      if (m_sidx != m_key) m_phase = 0;
      else if (m_settle == D - 1) begin
        fire = 1; m_held = code_tbl[m_key]; m_rep_cnt = 0; m_first_done = 0; m_phase = 2;
      end else m_settle++;
    end else if (m_phase == 2) begin
      if (m_sidx != m_key) begin m_settle = 1; m_phase = 3; end
      else if (RD != 0) begin
        need = m_first_done ? RP : RD;
        if (m_rep_cnt == need - 1) begin
          fire = 1; fire_rep = 1; m_rep_cnt = 0; m_first_done = 1;
        end else m_rep_cnt++;
      end
    end else begin
      if (m_sidx == m_key) m_phase = 2;
      else if (m_settle == D - 1) m_phase = 0;
      else m_settle++;
    end
    m_ovr = 0;
    if (fire) begin
      if (!m_vld || rdy) begin m_vld = 1; m_code = code_tbl[m_key]; m_rep = fire_rep; end
      else m_ovr = 1;
    end else if (m_vld && rdy) m_vld = 0;
    m_sidx = key_index(oh);
  endtask

  typedef struct {
    int         t;
    logic [3:0] c;
    logic       r;
  } ev_t;

  ev_t  evq[$];
  int   cyc = 0;
  int   kd_fall = -1;
  int   ovr_cnt = 0;
  logic pkd = 1'b0;
  bit   kd_any = 0;

  task automatic tick(input logic [15:0] oh, input logic rdy, input logic r);
    logic pv;
    @(negedge clk);
    onehot = oh; out_ready = rdy; rst = r;
    pv = out_valid;
    @(posedge clk);
    model_step(oh, rdy, r);
    #1;
    cyc++;
    check("out_valid", out_valid, m_vld);
    check("out_code", out_code, m_code);
    check("out_repeat", out_repeat, m_rep);
    check("key_down", key_down, (m_phase == 2 || m_phase == 3));
    check("held_code", held_code, m_held);
    check("overrun", overrun, m_ovr);
    if (out_valid && (!pv || rdy)) evq.push_back('{cyc, out_code, out_repeat});
    if (overrun) ovr_cnt++;
    if (key_down) kd_any = 1;
    if (pkd && !key_down) kd_fall = cyc;
    pkd = key_down;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vld"}, out_valid, 0);
    check({tag, "_code"}, out_code, 0);
    check({tag, "_rep"}, out_repeat, 0);
    check({tag, "_kd"}, key_down, 0);
    check({tag, "_held"}, held_code, 0);
    check({tag, "_ovr"}, overrun, 0);
  endtask

  int          base;
  int          exp_t [7] = '{4, 12, 15, 18, 23, 26, 29};
  int          len, kind, a, b;
  logic [15:0] v, vv;

  initial begin
    rst = 1'b1; onehot = '0; out_ready = 1'b0;
    tick(16'h0, 0, 1);
    tick(16'h0, 0, 1);
    check_zero("reset");

    // key7 press/release, latency and code
    base = cyc; evq.delete(); kd_fall = -1;
    repeat (10) tick(16'h0080, 1, 0);
    repeat (8) tick(16'h0000, 1, 0);
    check("t1_nev", evq.size(), 1);
    if (evq.size() > 0) begin
      check("t1_time", evq[0].t - base - 1, 4);
      check("t1_code", evq[0].c, 4'h1);
      check("t1_rep", evq[0].r, 0);
    end
    check("t1_held", held_code, 4'h1);
    check("t1_kdfall", kd_fall - base - 1, 14);

    // bounce on key5
    evq.delete(); kd_any = 0;
    repeat (2) tick(16'h0020, 1, 0);
    repeat (7) tick(16'h0000, 1, 0);
    check("t2_nev", evq.size(), 0);
    check("t2_kd", kd_any, 0);

    // ghosted pair, then key10 alone
    evq.delete();
    repeat (20) tick(16'h0440, 1, 0);
    check("t3_ghost", evq.size(), 0);
    base = cyc;
    repeat (8) tick(16'h0400, 1, 0);
    repeat (8) tick(16'h0000, 1, 0);
    check("t3_nev", evq.size(), 1);
    if (evq.size() > 0) begin
      check("t3_code", evq[0].c, 4'h5);
      check("t3_time", evq[0].t - base - 1, 4);
    end

    // key14 auto-repeat with a one-cycle dropout
    base = cyc; evq.delete();
    repeat (19) tick(16'h4000, 1, 0);
    tick(16'h0000, 1, 0);
    repeat (10) tick(16'h4000, 1, 0);
    repeat (10) tick(16'h0000, 1, 0);
    check("t4_nev", evq.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < evq.size()) begin
        check("t4_time", evq[i].t - base - 1, exp_t[i]);
        check("t4_code", evq[i].c, 4'h8);
        check("t4_rep", evq[i].r, (i != 0));
      end
    end

    // overrun with consumer stalled
    ovr_cnt = 0;
    repeat (6) tick(16'h0008, 0, 0);
    repeat (6) tick(16'h0000, 0, 0);
    repeat (6) tick(16'h2000, 0, 0);
    check("t5_ovr", ovr_cnt, 1);
    check("t5_code", out_code, 4'h0);
    check("t5_vld", out_valid, 1);
    tick(16'h2000, 1, 0);
    check("t5_clear", out_valid, 0);
    repeat (8) tick(16'h0000, 0, 0);

    // reset during debounce
    repeat (2) tick(16'h0040, 1, 0);
    tick(16'h0040, 1, 1);
    check_zero("t6a");
    base = cyc; evq.delete();
    repeat (8) tick(16'h0040, 1, 0);
    check("t6a_nev", evq.size(), 1);
    if (evq.size() > 0) check("t6a_time", evq[0].t - base - 1, 4);
    repeat (8) tick(16'h0000, 1, 0);

    // reset while held with a pending event
    repeat (6) tick(16'h0040, 0, 0);
    check("t6b_vld", out_valid, 1);
    tick(16'h0040, 0, 1);
    check_zero("t6b");
    base = cyc; evq.delete();
    repeat (8) tick(16'h0040, 1, 0);
    check("t6b_nev", evq.size(), 1);
    if (evq.size() > 0) begin
      check("t6b_time", evq[0].t - base - 1, 4);
      check("t6b_code", evq[0].c, 4'h2);
      check("t6b_rep", evq[0].r, 0);
    end
    repeat (8) tick(16'h0000, 1, 0);

    // random traffic against the model
    for (int s = 0; s < 250; s++) begin
      len  = $urandom_range(1, 24);
      kind = $urandom_range(0, 9);
      a    = $urandom_range(0, 15);
      b    = $urandom_range(0, 15);
      if (kind < 2) v = 16'h0;
      else if (kind < 8) v = 16'h1 << a;
      else v = (16'h1 << a) | (16'h1 << b);
      for (int k = 0; k < len; k++) begin
        vv = ($urandom_range(0, 19) == 0) ? 16'h0 : v;
        tick(vv, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
